// File: rtl/irq_controller_if.sv
`timescale 1ns/1ps
// Peripheral request/ack, CPU raise/ack and bus address/control signals of irq_controller.
// The shared data bus stays a plain inout on the module because it is bidirectional.
interface irq_controller_if #(
  parameter int NUM_IRQ = 8
);
  logic [NUM_IRQ-1:0] IRQ_REQ;
  logic [NUM_IRQ-1:0] IRQ_ACK;
  logic [NUM_IRQ-1:0] CPU_IRQ_RAISE;
  logic [NUM_IRQ-1:0] CPU_IRQ_ACK;
  logic [7:0]         BUS_ADDR;
  logic               BUS_WE;

  modport master (
    output IRQ_REQ, CPU_IRQ_ACK, BUS_ADDR, BUS_WE,
    input  IRQ_ACK, CPU_IRQ_RAISE
  );

  modport slave (
    input  IRQ_REQ, CPU_IRQ_ACK, BUS_ADDR, BUS_WE,
    output IRQ_ACK, CPU_IRQ_RAISE
  );
endinterface

// File: rtl/irq_controller.sv
`timescale 1ns/1ps
// Fixed-priority interrupt arbiter between level-request peripherals and a one-hot CPU interface,
// with MASK/PENDING/STATUS on an 8-bit bus. Define IRQ_SYNC_EN for a 2-flop request synchronizer.
module irq_controller #(
  parameter int         NUM_IRQ     = 8,
  parameter logic [7:0] BASE_ADDR   = 8'hF0,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RESETN,
  irq_controller_if.slave  bus,
  inout  wire  [7:0]       BUS_DATA
);

  localparam int         CW        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [7:0] ADDR_MASK = BASE_ADDR;
  localparam logic [7:0] ADDR_PEND = BASE_ADDR + 8'd1;
  localparam logic [7:0] ADDR_STAT = BASE_ADDR + 8'd2;

  typedef enum logic [1:0] {IDLE, RAISE, ACK, WAIT_DROP} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] req_in, req_q, mask_q, eligible;
  logic [NUM_IRQ-1:0] raise, ack;
  logic [2:0]         idx_q, idx_d, first_idx;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_set;
  logic               rd_en_q, rd_sel;
  logic [7:0]         rd_data_q, rd_data_d;
  logic [7:0]         mask8, pend8, status8;
  logic               wr_mask, wr_stat;

`ifdef IRQ_SYNC_EN
  // First synchronizer stage; req_q acts as the second.
  logic [NUM_IRQ-1:0] sync_q;
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) sync_q <= '0;
    else         sync_q <= bus.IRQ_REQ;
  end
  assign req_in = sync_q;
`else
  assign req_in = bus.IRQ_REQ;
`endif

  assign eligible = req_q & mask_q;

  always_comb begin
    first_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) first_idx = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    raise   = '0;
    ack     = '0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          idx_d   = first_idx;
          state_d = RAISE;
        end
      end
      RAISE: begin
        raise[idx_q] = 1'b1;
        // The CPU ack is checked first so it wins over a same-cycle mask clear.
        if (bus.CPU_IRQ_ACK[idx_q])  state_d = ACK;
        else if (!eligible[idx_q])   state_d = IDLE;
      end
      ACK: begin
        ack[idx_q] = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!req_q[idx_q]) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.CPU_IRQ_RAISE = raise;
  assign bus.IRQ_ACK       = ack;

  assign wr_mask = bus.BUS_WE && (bus.BUS_ADDR == ADDR_MASK);
  assign wr_stat = bus.BUS_WE && (bus.BUS_ADDR == ADDR_STAT);
  assign rd_sel  = !bus.BUS_WE && ((bus.BUS_ADDR == ADDR_MASK) ||
                                   (bus.BUS_ADDR == ADDR_PEND) ||
                                   (bus.BUS_ADDR == ADDR_STAT));

  always_comb begin
    mask8                = '0;
    pend8                = '0;
    mask8[NUM_IRQ-1:0]   = mask_q;
    pend8[NUM_IRQ-1:0]   = req_q;
    status8              = {err_q, 3'b000, state_q != IDLE, idx_q};
    rd_data_d            = '0;
    if (bus.BUS_ADDR == ADDR_MASK)      rd_data_d = mask8;
    else if (bus.BUS_ADDR == ADDR_PEND) rd_data_d = pend8;
    else if (bus.BUS_ADDR == ADDR_STAT) rd_data_d = status8;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      req_q     <= '0;
      mask_q    <= '1;
      rd_en_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      req_q     <= req_in;
      rd_en_q   <= rd_sel;
      rd_data_q <= rd_data_d;
      if (wr_mask) mask_q <= BUS_DATA[NUM_IRQ-1:0];
      // A timeout in the same cycle as the clear keeps ERR set.
      if (err_set)                     err_q <= 1'b1;
      else if (wr_stat && BUS_DATA[7]) err_q <= 1'b0;
    end
  end

  assign BUS_DATA = rd_en_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_irq_controller.sv
`timescale 1ns/1ps
// Directed bench for irq_controller: a vector table of single handshakes plus hand-written
// sequences for priority, masking, timeout and reset corner cases.
module tb_irq_controller;
  localparam logic [7:0] BASE = 8'hF0;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       tb_drive = 1'b0;
  logic [7:0] tb_wdata = 8'h00;
  wire  [7:0] bus_data;
  int         checks   = 0;
  int         errors   = 0;

  irq_controller_if #(.NUM_IRQ(8)) bus ();

  irq_controller #(.NUM_IRQ(8), .BASE_ADDR(BASE), .ACK_TIMEOUT(15)) dut (
    .CLK      (clk),
    .RESETN   (resetn),
    .bus      (bus),
    .BUS_DATA (bus_data)
  );

  assign bus_data = tb_drive ? tb_wdata : 8'hzz;
  pulldown pd_i (bus_data);

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] exp_raise;
    logic [7:0] exp_status;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
    bus.BUS_ADDR = addr;
    bus.BUS_WE   = 1'b0;
    tick();
    data = bus_data;
    bus.BUS_ADDR = 8'h00;
    tick();
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    tb_drive     = 1'b1;
    tb_wdata     = data;
    bus.BUS_ADDR = addr;
    bus.BUS_WE   = 1'b1;
    tick();
    tb_drive     = 1'b0;
    bus.BUS_WE   = 1'b0;
    bus.BUS_ADDR = 8'h00;
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      checks++;
      if (!$onehot0(bus.CPU_IRQ_RAISE) || !$onehot0(bus.IRQ_ACK) ||
          ((|bus.CPU_IRQ_RAISE) && (|bus.IRQ_ACK))) begin
        errors++;
        $display("FAIL invariant: raise 0x%0h ack 0x%0h, required one-hot-or-zero and not both",
                 bus.CPU_IRQ_RAISE, bus.IRQ_ACK);
      end
    end
  end

  initial begin
    logic [7:0] d;
    int         n;
    logic       got;

    vecs[0] = '{8'h04, 8'h04, 8'h02};
    vecs[1] = '{8'h81, 8'h01, 8'h00};
    vecs[2] = '{8'h80, 8'h80, 8'h07};
    vecs[3] = '{8'h06, 8'h02, 8'h01};
    vecs[4] = '{8'h10, 8'h10, 8'h04};
    vecs[5] = '{8'h00, 8'h00, 8'h04};

    bus.IRQ_REQ     = 8'h00;
    bus.CPU_IRQ_ACK = 8'h00;
    bus.BUS_ADDR    = 8'h00;
    bus.BUS_WE      = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_raise", bus.CPU_IRQ_RAISE, 8'h00);
    check("rst_ack", bus.IRQ_ACK, 8'h00);
    #5 resetn = 1'b1;
    tick();
    bus_read(BASE, d);          check("rst_mask", d, 8'hFF);
    check("bus_released", bus_data, 8'h00);
    bus_read(BASE + 8'd1, d);   check("rst_pending", d, 8'h00);
    bus_read(BASE + 8'd2, d);   check("rst_status", d, 8'h00);

    // Table: single handshakes with exact latency
    foreach (vecs[i]) begin
      bus.IRQ_REQ = vecs[i].req;
      tick();
      check("raise_lat1", bus.CPU_IRQ_RAISE, 8'h00);
      tick();
      check("raise_lat2", bus.CPU_IRQ_RAISE, vecs[i].exp_raise);
      if (vecs[i].exp_raise != 8'h00) begin
        bus.CPU_IRQ_ACK = vecs[i].exp_raise;
        tick();
        check("irq_ack", bus.IRQ_ACK, vecs[i].exp_raise);
        check("raise_off_in_ack", bus.CPU_IRQ_RAISE, 8'h00);
        bus.CPU_IRQ_ACK = 8'h00;
        bus.IRQ_REQ     = 8'h00;
        tick();
        check("ack_one_cycle", bus.IRQ_ACK, 8'h00);
      end
      bus.IRQ_REQ = 8'h00;
      tick(); tick(); tick();
      bus_read(BASE + 8'd2, d);
      check("status_idle", d, vecs[i].exp_status);
    end

    // Priority: 0x81 serves bit 0, ignores a wrong-bit ack, then serves bit 7
    bus.IRQ_REQ = 8'h81;
    tick(); tick();
    check("prio_first", bus.CPU_IRQ_RAISE, 8'h01);
    bus.CPU_IRQ_ACK = 8'h80;
    tick();
    check("wrong_ack_raise", bus.CPU_IRQ_RAISE, 8'h01);
    check("wrong_ack_noack", bus.IRQ_ACK, 8'h00);
    bus.CPU_IRQ_ACK = 8'h00;
    bus_read(BASE + 8'd1, d);   check("prio_pending", d, 8'h81);
    bus.CPU_IRQ_ACK = 8'h01;
    tick();
    check("prio_ack0", bus.IRQ_ACK, 8'h01);
    bus.CPU_IRQ_ACK = 8'h00;
    bus.IRQ_REQ     = 8'h80;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (bus.CPU_IRQ_RAISE == 8'h80) got = 1'b1;
    end
    check("prio_second_raise", got, 1'b1);
    bus.CPU_IRQ_ACK = 8'h80;
    tick();
    check("prio_ack7", bus.IRQ_ACK, 8'h80);
    bus.CPU_IRQ_ACK = 8'h00;
    bus.IRQ_REQ     = 8'h00;
    tick(); tick(); tick();

    // Mask write withdraws the raise without an ack
    bus.IRQ_REQ = 8'h01;
    tick(); tick();
    check("mask_pre_raise", bus.CPU_IRQ_RAISE, 8'h01);
    bus_write(BASE, 8'hFE);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("masked_raise", bus.CPU_IRQ_RAISE, 8'h00);
      check("masked_noack", bus.IRQ_ACK, 8'h00);
      tick();
    end
    bus_read(BASE + 8'd1, d);   check("masked_pending", d, 8'h01);
    bus_read(BASE, d);          check("mask_readback", d, 8'hFE);
    bus_write(BASE, 8'hFF);
    tick();
    check("unmask_raise", bus.CPU_IRQ_RAISE, 8'h01);

    // Mask clear and CPU ack in the same cycle: the ack wins
    tb_drive        = 1'b1;
    tb_wdata        = 8'hFE;
    bus.BUS_ADDR    = BASE;
    bus.BUS_WE      = 1'b1;
    bus.CPU_IRQ_ACK = 8'h01;
    tick();
    tb_drive        = 1'b0;
    bus.BUS_WE      = 1'b0;
    bus.BUS_ADDR    = 8'h00;
    bus.CPU_IRQ_ACK = 8'h00;
    check("ack_beats_mask", bus.IRQ_ACK, 8'h01);
    bus.IRQ_REQ = 8'h00;
    tick(); tick(); tick();
    bus_write(BASE, 8'hFF);

    // Timeout: request held after ack sets ERR and re-raises
    bus.IRQ_REQ = 8'h04;
    tick(); tick();
    check("to_raise", bus.CPU_IRQ_RAISE, 8'h04);
    bus.CPU_IRQ_ACK = 8'h04;
    tick();
    check("to_ack", bus.IRQ_ACK, 8'h04);
    bus.CPU_IRQ_ACK = 8'h00;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      tick();
      n++;
      if (bus.CPU_IRQ_RAISE == 8'h04) got = 1'b1;
    end
    check("to_reraise", got, 1'b1);
    check("to_not_early", (n >= 15 && n <= 18), 1'b1);
    bus_read(BASE + 8'd2, d);   check("to_status_err", d, 8'h8A);
    bus_write(BASE + 8'd2, 8'h80);
    bus_read(BASE + 8'd2, d);   check("err_cleared", d, 8'h0A);
    bus.IRQ_REQ = 8'h00;
    tick(); tick(); tick();
    bus_read(BASE + 8'd2, d);   check("to_idle", d, 8'h02);

    // Reset during ACK drops outputs immediately and restores MASK
    bus_write(BASE, 8'h7F);
    bus.IRQ_REQ = 8'h04;
    tick(); tick();
    check("rst_pre_raise", bus.CPU_IRQ_RAISE, 8'h04);
    bus.CPU_IRQ_ACK = 8'h04;
    tick();
    check("rst_pre_ack", bus.IRQ_ACK, 8'h04);
    resetn = 1'b0;
    #2;
    check("async_rst_ack", bus.IRQ_ACK, 8'h00);
    check("async_rst_raise", bus.CPU_IRQ_RAISE, 8'h00);
    bus.CPU_IRQ_ACK = 8'h00;
    bus.IRQ_REQ     = 8'h00;
    tick();
    #5 resetn = 1'b1;
    tick();
    check("post_rst_ack", bus.IRQ_ACK, 8'h00);
    bus_read(BASE, d);          check("post_rst_mask", d, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt arbiter between bus peripherals (switches, mouse, timer, ...) and the CPU.
- Peripheral side: each peripheral holds a request line high until it receives an ack; this block drives those ack lines.
- CPU side: presents one one-hot interrupt at a time and takes the CPU's one-hot ack.
- Mask, pending and status registers are readable/writable over the shared 8-bit data bus.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..8); index 0 is highest priority.
- BASE_ADDR, 8'hF0, bus address of the first register; the block decodes BASE_ADDR..BASE_ADDR+2.
- ACK_TIMEOUT, 15, cycles to wait for a peripheral to drop its request after ack.

Ports:
- CLK  in  1  system clock, 50 MHz
- RESETN  in  1  reset, asynchronous, active-low
- IRQ_REQ  in  NUM_IRQ  level requests from peripherals (their SEND_INTERRUPT)
- IRQ_ACK  out  NUM_IRQ  one-cycle ack pulses to peripherals (their INTERRUPT_ACK)
- CPU_IRQ_RAISE  out  NUM_IRQ  one-hot interrupt to CPU
- CPU_IRQ_ACK  in  NUM_IRQ  one-hot ack from CPU
- BUS_DATA  inout  8  shared data bus
- BUS_ADDR  in  8  bus address
- BUS_WE  in  1  bus write enable

Behaviour:
- Reset (asynchronous, any state):
  - IRQ_ACK=0, CPU_IRQ_RAISE=0, BUS_DATA released (Z).
  - Mask=all ones, state=IDLE, timeout counter=0, ERR=0.
  - Reset mid-handshake drops the raise immediately and issues no ack.
- Request path: IRQ_REQ is registered once into req_q (see optional feature). eligible = req_q & mask.
- Registers:
  - BASE+0 MASK: read/write. A write with BUS_WE=1 updates MASK at the next CLK edge; bits >= NUM_IRQ read 0 and ignore writes.
  - BASE+1 PENDING: read-only, {0.., req_q}.
  - BASE+2 STATUS: read-only. bit7=ERR (sticky); bits2:0=index of the in-service source; bit3=busy (state != IDLE).
  - Writing 1 to BASE+2 bit7 clears ERR.
- Bus read timing:
  - Read enable and read data are both registered.
  - BUS_DATA is driven one cycle after the address is valid with BUS_WE=0; otherwise Z.
  - Writes never drive the bus.
- State machine:
  - IDLE: if eligible != 0, latch k = lowest set index, go RAISE.
  - RAISE: CPU_IRQ_RAISE = onehot(k).
    - If CPU_IRQ_ACK[k]=1, go ACK.
    - Else if eligible[k]=0 (masked or request withdrawn), drop the raise and go IDLE; no ack is issued.
    - A CPU_IRQ_ACK on any bit other than k is ignored.
  - ACK: CPU_IRQ_RAISE=0, IRQ_ACK[k]=1 for exactly one cycle, clear timeout counter, go WAIT_DROP.
  - WAIT_DROP: wait for req_q[k]=0, then go IDLE.
    - If the counter reaches ACK_TIMEOUT first, set ERR and go IDLE.
    - Source k is then treated as a fresh request.
- Priority:
  - Fixed priority, re-evaluated only in IDLE.
  - A higher-priority request arriving during RAISE does not preempt the source in service.
- Latency (without the optional feature): IRQ_REQ rise -> CPU_IRQ_RAISE high = 2 cycles (register + IDLE decision). CPU_IRQ_ACK -> IRQ_ACK pulse = 1 cycle.
- Simultaneous events:
  - A mask write that clears bit k in the same cycle as CPU_IRQ_ACK[k]: the ack wins, so the ACK state is entered.
  - Requests arriving while busy stay visible in PENDING and are serviced in priority order afterwards.
- Invariants: at most one CPU_IRQ_RAISE bit and one IRQ_ACK bit high at any time; never both asserted in the same cycle.

Optional Feature:
- IRQ_SYNC_EN defined: IRQ_REQ passes through a 2-flop synchronizer before req_q, for asynchronous sources. Request-to-raise latency becomes 3 cycles, and all WAIT_DROP timing shifts by the same amount.
- Not defined: single register stage only; latency as stated under Behaviour.

Test Plan:
- Reset, then read BASE+0 -> 0xFF. Read BASE+1 -> 0x00. All outputs 0; BUS_DATA Z outside reads.
- IRQ_REQ=0x04 -> CPU_IRQ_RAISE=0x04 two cycles later. CPU_IRQ_ACK=0x04 -> IRQ_ACK=0x04 for 1 cycle. Drop IRQ_REQ -> back to IDLE, STATUS bit3=0.
- IRQ_REQ=0x81 simultaneously -> source 0 serviced first. After its request drops, CPU_IRQ_RAISE=0x80.
- Write MASK=0xFE while CPU_IRQ_RAISE=0x01 -> raise drops next cycle, no IRQ_ACK, IRQ_REQ[0] still visible in PENDING.
- Peripheral holds IRQ_REQ[2] high after ack -> after 15 cycles STATUS bit7=1 and a new raise of 0x04. Write 0x80 to BASE+2 -> ERR clears.
- Assert RESETN low during ACK state -> IRQ_ACK and CPU_IRQ_RAISE go 0 immediately; MASK returns to 0xFF.
